// File: rtl/cla_add_seq.sv
// Multi-cycle add/subtract unit: one shared 4-bit carry-lookahead slice is
// stepped across the operands one nibble per clock, LSB nibble first.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end
endmodule

module cla_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovfl,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [N-1:0][3:0]   opa_q, opa_d;
    logic [N-1:0][3:0]   opb_q, opb_d;
    logic [N-1:0][3:0]   s_q, s_d;
    logic                carry_q, carry_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                cout_q, cout_d;
    logic                ovfl_q, ovfl_d;
    logic                zero_q, zero_d;

    logic [3:0]          slice_s;
    logic                slice_cout;
    logic                last_step;

    cla4 u_slice (
        .a    (opa_q[idx_q]),
        .b    (opb_q[idx_q]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign last_step = (idx_q == IW'(N - 1));

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1: the +1 rides in on the first carry-in.
                    opa_d   = A;
                    opb_d   = sub ? ~B : B;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q] = slice_s;
                carry_d    = slice_cout;
                if (last_step) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovfl_d  = (opa_q[N-1][3] == opb_q[N-1][3]) && (slice_s[3] != opa_q[N-1][3]);
                    zero_d  = (s_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovfl      = ovfl_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_cla_add_seq.sv
// Self-checking bench for cla_add_seq: expected results are queued on accept
// and compared when the result handshake is observed.

module tb_cla_add_seq;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovfl;
        logic             zero;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovfl;
    logic             zero;

    int   checks   = 0;
    int   failures = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    res_t sb[$];
    bit   stream_done;

    cla_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovfl      (ovfl),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic s_op);
        res_t             r;
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   full;
        bx     = s_op ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, s_op};
        r.s    = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovfl = (a[WIDTH-1] == bx[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        r.zero = (r.s == '0);
        return r;
    endfunction

    // Result monitor: a DONE cycle seen with out_ready high completes at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                n_popped++;
                check("S", 32'(S), 32'(e.s));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovfl", 32'(ovfl), 32'(e.ovfl));
                check("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    // Presents one request and returns 1ns after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s_op,
                        input res_t exp);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        sub      = s_op;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                n_pushed++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        A        = WIDTH'($urandom);
        B        = WIDTH'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_flags", {29'd0, cout, ovfl, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with latency check.
        send(16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, cout: 1'b0, ovfl: 1'b0, zero: 1'b0});
        for (int e = 1; e < N; e++) begin
            @(posedge clk);
            #1;
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("latency_out_valid", 32'(out_valid), 32'd1);
        drain();

        send(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, cout: 1'b1, ovfl: 1'b0, zero: 1'b1});
        send(16'h7FFF, 16'h0001, 1'b0, '{s: 16'h8000, cout: 1'b0, ovfl: 1'b1, zero: 1'b0});
        send(16'h0005, 16'h0007, 1'b1, '{s: 16'hFFFE, cout: 1'b0, ovfl: 1'b0, zero: 1'b0});
        send(16'h8000, 16'h0001, 1'b1, '{s: 16'h7FFF, cout: 1'b1, ovfl: 1'b1, zero: 1'b0});
        drain();

        // Backpressure: result must hold while inputs churn.
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, '{s: 16'h0100, cout: 1'b0, ovfl: 1'b0, zero: 1'b0});
        begin
            int i;
            for (i = 0; i < 50 && !out_valid; i++) @(negedge clk);
            check("bp_reach_done", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            A        = WIDTH'($urandom);
            B        = WIDTH'($urandom);
            sub      = 1'($urandom);
            @(negedge clk);
            check("bp_S", 32'(S), 32'h0100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        // Release the result while a new request is already pending.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = 16'h0003;
        B         = 16'h0004;
        sub       = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_popped", 32'(sb.size()), 32'd0);
        send(16'h0003, 16'h0004, 1'b0, '{s: 16'h0007, cout: 1'b0, ovfl: 1'b0, zero: 1'b0});
        drain();

        // Random stream with random consumer stalls.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [WIDTH-1:0] a, b;
                    logic             s_op;
                    a    = WIDTH'($urandom);
                    b    = WIDTH'($urandom);
                    s_op = 1'($urandom);
                    if (i == 3) b = a;
                    send(a, b, s_op, ref_model(a, b, s_op));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 32'(n_popped), 32'(n_pushed));

        // Asynchronous reset in the middle of RUN.
        send(16'hABCD, 16'h1111, 1'b0, ref_model(16'hABCD, 16'h1111, 1'b0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_S", 32'(S), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0002, 1'b0, '{s: 16'h0003, cout: 1'b0, ovfl: 1'b0, zero: 1'b0});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
